// File: rtl/sram_arbiter.sv
// Frame-buffer SRAM arbiter: prioritised scan-out reads, FIFO-buffered pixel writes
// retired in idle slots or forced after STARVE_MAX read grants with a write pending.
module sram_arbiter #(
  parameter int unsigned AW          = 20,
  parameter int unsigned DW          = 16,
  parameter int unsigned WFIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX  = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rd_req,
  input  logic [AW-1:0]                  rd_addr,
  output logic                           rd_gnt,
  output logic                           rd_valid,
  output logic [DW-1:0]                  rd_data,
  input  logic                           wr_valid,
  input  logic [AW-1:0]                  wr_addr,
  input  logic [DW-1:0]                  wr_data,
  output logic                           wr_ready,
  output logic [$clog2(WFIFO_DEPTH):0]   wr_level,
  output logic [AW-1:0]                  sram_addr,
  output logic [DW-1:0]                  sram_dq_out,
  output logic                           sram_dq_oe,
  input  logic [DW-1:0]                  sram_dq_in,
  output logic                           ce_n,
  output logic                           oe_n,
  output logic                           we_n,
  output logic                           ub_n,
  output logic                           lb_n
);
  localparam int unsigned PW = $clog2(WFIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
  state_t state, state_nxt;

  logic [AW-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DW-1:0] fifo_data [WFIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [LW-1:0] level;
  logic [SW-1:0] starve_cnt;
  logic          fifo_empty, push, pop, forced;

  assign fifo_empty = (level == '0);
  assign wr_ready   = (level != LW'(WFIFO_DEPTH));
  assign wr_level   = level;
  assign push       = wr_valid && wr_ready;
  assign forced     = !fifo_empty && (starve_cnt == SW'(STARVE_MAX));

  // IDLE, RD and WR_HOLD are decision cycles; SETUP/PULSE run unconditionally
  always_comb begin
    state_nxt = state;
    rd_gnt    = 1'b0;
    pop       = 1'b0;
    unique case (state)
      WR_SETUP: state_nxt = WR_PULSE;
      WR_PULSE: state_nxt = WR_HOLD;
      default: begin
        if (forced) begin
          state_nxt = WR_SETUP;
          pop       = 1'b1;
        end else if (rd_req) begin
          state_nxt = RD;
          rd_gnt    = 1'b1;
        end else if (!fifo_empty) begin
          state_nxt = WR_SETUP;
          pop       = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr] <= wr_addr;
      fifo_data[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (rd_gnt && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Pins are registered from the next state so each state shows its own strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ce_n        <= 1'b1;
      ub_n        <= 1'b1;
      lb_n        <= 1'b1;
      oe_n        <= 1'b1;
      we_n        <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      state      <= state_nxt;
      rd_valid   <= (state == RD);
      if (state == RD) rd_data <= sram_dq_in;
      ce_n       <= (state_nxt == IDLE);
      ub_n       <= (state_nxt == IDLE);
      lb_n       <= (state_nxt == IDLE);
      oe_n       <= (state_nxt != RD);
      we_n       <= (state_nxt != WR_PULSE);
      sram_dq_oe <= (state_nxt == WR_PULSE) || (state_nxt == WR_HOLD);
      if (rd_gnt) sram_addr <= rd_addr;
      if (pop) begin
        sram_addr   <= fifo_addr[rptr];
        sram_dq_out <= fifo_data[rptr];
      end
    end
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Single-port SRAM arbiter sharing the 16-bit, 1M-word frame-buffer SRAM between the VGA scan-out reader and a pixel writer (scale generator or Julia calculator). It owns every SRAM control pin, the address bus and the data-bus tristate enable, so readers and writers never drive the SRAM directly.
- Reads have priority for display continuity.
- Writes are buffered in a small FIFO and retired in idle slots, or forcibly after a starvation limit.

## Interface
- AW, 20, SRAM address width
- DW, 16, SRAM data width
- WFIFO_DEPTH, 4, write FIFO entries (power of 2, ≥2)
- STARVE_MAX, 64, consecutive read grants with a pending write before a write is forced (≥1)

- clk  in  1  system clock (108 MHz domain)
- rst  in  1  asynchronous, active-low reset
- rd_req  in  1  read request, level, one word per granted cycle
- rd_addr  in  AW  read address
- rd_gnt  out  1  read accepted this cycle (combinational)
- rd_valid  out  1  rd_data valid, one pulse per grant
- rd_data  out  DW  read data
- wr_valid  in  1  write push request
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- wr_ready  out  1  FIFO not full
- wr_level  out  clog2(WFIFO_DEPTH)+1  FIFO occupancy
- sram_addr  out  AW  SRAM address (registered)
- sram_dq_out  out  DW  data to drive onto bus (registered)
- sram_dq_oe  out  1  1 = top level drives sram_dq_out, else high-Z (registered)
- sram_dq_in  in  DW  bus sampled data
- ce_n, oe_n, we_n, ub_n, lb_n  out  1 each  SRAM strobes (registered, active-low)

## Operation
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- Decision cycles: IDLE, RD, WR_HOLD. Next state is chosen in these cycles:
  - Forced write: FIFO non-empty and starve_cnt == STARVE_MAX -> WR_SETUP.
  - Otherwise rd_req=1 -> RD, rd_gnt=1.
  - Otherwise FIFO non-empty -> WR_SETUP.
  - Otherwise IDLE.
- rd_gnt is 0 in WR_SETUP and WR_PULSE. A write sequence is atomic and is never preempted.
- Strobes per state (registered values seen during the state):
  - IDLE: ce_n=ub_n=lb_n=oe_n=we_n=1, dq_oe=0.
  - RD: ce_n=ub_n=lb_n=oe_n=0, we_n=1, dq_oe=0, sram_addr = granted rd_addr.
  - WR_SETUP: ce_n=ub_n=lb_n=0, oe_n=we_n=1, dq_oe=0 (bus turnaround), sram_addr = FIFO head address.
  - WR_PULSE: we_n=0, dq_oe=1, sram_dq_out = head data.
  - WR_HOLD: we_n=1, dq_oe=1, address and data held.
- FIFO pop occurs on the cycle entering WR_SETUP.
- Push occurs when wr_valid && wr_ready. No push is possible when full. Simultaneous push and pop when non-full is legal and leaves wr_level unchanged.
- starve_cnt:
  - Increments on each rd_gnt while FIFO is non-empty, saturating at STARVE_MAX.
  - Clears on entry to WR_SETUP and whenever the FIFO is empty.
- wr_level wraps nothing: count 0..WFIFO_DEPTH. Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Read latency: grant in cycle T; SRAM access (oe_n=0, address valid) in T+1; sram_dq_in sampled at end of T+1; rd_valid/rd_data in T+2.
- Back-to-back reads: 1 word/clock.
- Write: 3 cycles per word. we_n is low exactly 1 cycle, with address and data stable one cycle before and after.
- Consecutive writes: WR_HOLD -> WR_SETUP. The next read may be granted in WR_HOLD, with RD in the following cycle.
- Reset (asynchronous, rst=0), applies immediately, including mid-write or mid-read:
  - All strobes 1, dq_oe=0, sram_addr=0, sram_dq_out=0.
  - rd_valid=0, rd_data=0, state IDLE, FIFO flushed (wr_level=0), starve_cnt=0.
  - In-flight reads produce no rd_valid.
- Out of reset: wr_ready=1.

## Test plan
- Reset mid-write: pull rst low during WR_PULSE -> we_n=1 and dq_oe=0 immediately; wr_level=0; no rd_valid after release.
- Single read: rd_req=1, rd_addr=0x00123, model returns 0xBEEF -> rd_gnt same cycle; T+1 sram_addr=0x00123 with oe_n=0; T+2 rd_valid=1 with rd_data=0xBEEF; exactly one pulse.
- Single write, rd_req=0: push (0x00400, 0xF800) -> WR_SETUP with dq_oe=0; we_n=0 for one cycle; sram_dq_out=0xF800 during PULSE and HOLD; then IDLE with all strobes 1.
- FIFO full: rd_req held 1, push 5 writes with DEPTH=4 -> wr_ready=0 after the 4th; wr_level=4; 5th held until the first forced write pops.
- Starvation: STARVE_MAX=8, rd_req constant, one queued write -> exactly 8 rd_gnt pulses, then rd_gnt=0 for 2 cycles (SETUP, PULSE), granted again in HOLD; the write completes.
- Read during write: rd_req rises in WR_SETUP -> not granted until WR_HOLD; rd_valid follows 2 cycles after that grant with correct data.
